// File: rtl/kawari_math_pkg.sv
// Shared definitions for the register-mapped math block (multiply and divide units).
package kawari_math_pkg;

  localparam int unsigned MathWidth = 16;
  // One partial-product (or quotient) step per operand bit.
  localparam int unsigned MathSteps = MathWidth;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2
  } math_state_e;

endpackage

// File: rtl/sign_mag.sv
// Conditional two's-complement negate: result = negate ? -value : value.
module sign_mag #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    if (negate) begin
      result = ~value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/multiply.sv
// Sequential shift-add multiplier, signed or unsigned, one partial-product step per clock.
// Optional accumulator is enabled with the MULTIPLY_ACCUM_EN macro.
module multiply
  import kawari_math_pkg::*;
#(
  parameter int unsigned WIDTH = MathWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               accumulate,
  input  logic               acc_clr,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  math_state_e      state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW:0]      partial_q;
  logic             neg_q;
  logic             sign_q;
  logic             done_q;
  logic             overflow_q;
  logic [PW-1:0]    product_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [PW:0]      partial_sum;
  logic [PW-1:0]    result;
  logic             result_ovf;

  sign_mag #(.WIDTH(WIDTH)) u_abs_a (
    .value  (multiplicand),
    .negate (sign & multiplicand[WIDTH-1]),
    .result (a_abs)
  );

  sign_mag #(.WIDTH(WIDTH)) u_abs_b (
    .value  (multiplier),
    .negate (sign & multiplier[WIDTH-1]),
    .result (b_abs)
  );

  sign_mag #(.WIDTH(PW)) u_result (
    .value  (partial_q[PW-1:0]),
    .negate (neg_q),
    .result (result)
  );

  // The add keeps its carry in the top bit so the following shift brings it back in.
  always_comb begin
    partial_sum = partial_q;
    if (mcand_q[0]) begin
      partial_sum = partial_q + {1'b0, mplier_q, {WIDTH{1'b0}}};
    end
  end

  always_comb begin
    if (sign_q) begin
      result_ovf = result[PW-1:WIDTH] != {WIDTH{result[WIDTH-1]}};
    end else begin
      result_ovf = result[PW-1:WIDTH] != '0;
    end
  end

`ifdef MULTIPLY_ACCUM_EN
  logic [PW-1:0] acc_q;
  logic          acc_mode_q;
  logic [PW:0]   acc_sum;
  logic          acc_wrap;

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, result};
    if (sign_q) begin
      acc_wrap = (acc_q[PW-1] == result[PW-1]) && (acc_sum[PW-1] != acc_q[PW-1]);
    end else begin
      acc_wrap = acc_sum[PW];
    end
  end
`else
  // Ports kept for a stable interface with the accumulator build.
  logic unused_acc_ports;
  assign unused_acc_ports = accumulate ^ acc_clr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      partial_q  <= '0;
      neg_q      <= 1'b0;
      sign_q     <= 1'b0;
      done_q     <= 1'b1;
      overflow_q <= 1'b0;
      product_q  <= '0;
`ifdef MULTIPLY_ACCUM_EN
      acc_q      <= '0;
      acc_mode_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
`ifdef MULTIPLY_ACCUM_EN
          if (acc_clr) begin
            acc_q <= '0;
          end
`endif
          if (start) begin
            mcand_q   <= a_abs;
            mplier_q  <= b_abs;
            neg_q     <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            sign_q    <= sign;
            partial_q <= '0;
            cnt_q     <= CntW'(WIDTH);
            done_q    <= 1'b0;
            state_q   <= StRun;
`ifdef MULTIPLY_ACCUM_EN
            acc_mode_q <= accumulate;
`endif
          end
        end
        StRun: begin
          partial_q <= partial_sum >> 1;
          mcand_q   <= mcand_q >> 1;
          cnt_q     <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
`ifdef MULTIPLY_ACCUM_EN
          if (acc_mode_q) begin
            acc_q      <= acc_sum[PW-1:0];
            product_q  <= acc_sum[PW-1:0];
            overflow_q <= result_ovf | acc_wrap;
          end else begin
            product_q  <= result;
            overflow_q <= result_ovf;
          end
`else
          product_q  <= result;
          overflow_q <= result_ovf;
`endif
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign done     = done_q;
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_multiply.sv
// Scoreboard bench for multiply: stimulus pushes expected results, a monitor checks on done.
module tb_multiply;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic        accumulate = 1'b0;
  logic        acc_clr = 1'b0;
  logic        done;
  logic [31:0] product;
  logic        overflow;

  multiply dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sign         (sign),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .accumulate   (accumulate),
    .acc_clr      (acc_clr),
    .done         (done),
    .product      (product),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_prod = '0;
  logic        last_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; waits for done, issues one start, returns one cycle later.
  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic acc, input logic [31:0] ep, input logic eo);
    int t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("issue_ready", {31'b0, done}, 32'd1);
    sign         = s;
    multiplicand = a;
    multiplier   = b;
    accumulate   = acc;
    start        = 1'b1;
    exp_q.push_back('{ep, eo});
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = 16'hDEAD;
    multiplier   = 16'hBEEF;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("idle_wait", {31'b0, done}, 32'd1);
  endtask

  // Monitor: samples on the falling edge, checks latency, hold-during-run and results.
  initial begin
    logic done_prev = 1'b1;
    int   low_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_prev = 1'b1;
        low_cnt   = 0;
        last_prod = '0;
        last_ovf  = 1'b0;
      end else begin
        if (done === 1'b0) begin
          low_cnt++;
          if (low_cnt == 8) begin
            check("hold_product", product, last_prod);
            check("hold_overflow", {31'b0, overflow}, {31'b0, last_ovf});
          end
        end else if (done_prev === 1'b0) begin
          check("latency", 32'(low_cnt), 32'd17);
          check("pending", {31'b0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("product", product, e.prod);
            check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
            last_prod = e.prod;
            last_ovf  = e.ovf;
          end
          low_cnt = 0;
        end
        done_prev = done;
      end
    end
  end

  initial begin
    int t;
    #2 rst_n = 1'b0;
    #1;
    check("reset_done", {31'b0, done}, 32'd1);
    check("reset_product", product, 32'h0);
    check("reset_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(1'b0, 16'd300, 16'd200, 1'b0, 32'h0000_EA60, 1'b0);
    issue(1'b1, 16'hFFF9, 16'd9, 1'b0, 32'hFFFF_FFC1, 1'b0);
    issue(1'b1, 16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 1'b1);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b1);
    issue(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'h0000_0001, 1'b0);
    issue(1'b1, 16'h0000, 16'hFFFB, 1'b0, 32'h0000_0000, 1'b0);
    issue(1'b1, 16'd100, 16'hFED4, 1'b0, 32'hFFFF_8AD0, 1'b0);
    issue(1'b1, 16'd200, 16'd200, 1'b0, 32'h0000_9C40, 1'b1);
    issue(1'b0, 16'd256, 16'd256, 1'b0, 32'h0001_0000, 1'b1);
    issue(1'b0, 16'd255, 16'd257, 1'b0, 32'h0000_FFFF, 1'b0);

    // Start pulsed mid-run must be dropped, not queued.
    issue(1'b0, 16'd1000, 16'd1000, 1'b0, 32'h000F_4240, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start        = 1'b1;
    multiplicand = 16'd2;
    multiplier   = 16'd3;
    @(posedge clk);
    #1 start = 1'b0;

    // Back-to-back: the second start lands on the edge done is first seen high.
    issue(1'b0, 16'd7, 16'd6, 1'b0, 32'h0000_002A, 1'b0);
    issue(1'b1, 16'hFFFF, 16'd1, 1'b0, 32'hFFFF_FFFF, 1'b0);

    // Reset around step 8 aborts the run.
    issue(1'b0, 16'd12345, 16'd3, 1'b0, 32'h0, 1'b0);
    repeat (7) @(posedge clk);
    #3;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("abort_done", {31'b0, done}, 32'd1);
    check("abort_product", product, 32'h0);
    check("abort_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(1'b0, 16'd3, 16'd4, 1'b0, 32'h0000_000C, 1'b0);

`ifdef MULTIPLY_ACCUM_EN
    wait_idle();
    acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    issue(1'b0, 16'd1000, 16'd1000, 1'b1, 32'h000F_4240, 1'b1);
    issue(1'b0, 16'd1000, 16'd1000, 1'b1, 32'h001E_8480, 1'b1);
    issue(1'b0, 16'd1000, 16'd1000, 1'b1, 32'h002D_C6C0, 1'b1);
    issue(1'b0, 16'd2, 16'd3, 1'b0, 32'h0000_0006, 1'b0);
    issue(1'b0, 16'd0, 16'd0, 1'b1, 32'h002D_C6C0, 1'b0);
`else
    wait_idle();
    acc_clr = 1'b1;
    issue(1'b0, 16'd5, 16'd5, 1'b1, 32'h0000_0019, 1'b0);
    acc_clr = 1'b0;
    issue(1'b0, 16'd6, 16'd7, 1'b1, 32'h0000_002A, 1'b0);
`endif
    accumulate = 1'b0;

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
